// File: rtl/timer_if.sv
// Register-bus bundle between a host and the interval timer:
// address/write-strobe/data toward the timer, read data and interrupt back.
interface timer_if;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              irq;

  modport master (output addr, we, din, input dout, irq);
  modport slave  (input addr, we, din, output dout, irq);
endinterface

// File: rtl/timer_irq.sv
// Programmable down-counting interval timer with one-shot and auto-reload modes,
// raising a maskable interrupt flag on expiry.
module timer_irq (
  input  logic     clk,
  input  logic     rst,
  timer_if.slave   bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [CTRL_W-1:0]   ctrl, ctrl_n;
  logic [DATA_W-1:0]   preset, preset_n;
  logic [DATA_W-1:0]   count, count_n;
  logic                irq_flag, irq_flag_n;

  logic wr_ctrl;
  logic wr_preset;
  logic en;
  logic im;
  logic auto_reload;

  assign wr_ctrl     = bus.we && (bus.addr == ADDR_CTRL);
  assign wr_preset   = bus.we && (bus.addr == ADDR_PRESET);
  assign en          = ctrl[0];
  assign im          = ctrl[3];
  assign auto_reload = (ctrl[2:1] == 2'b01);

  // State and register update
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_n;
      ctrl     <= ctrl_n;
      preset   <= preset_n;
      count    <= count_n;
      irq_flag <= irq_flag_n;
    end
  end

  // Next-state and next register values; software writes override the sequencer
  always_comb begin
    state_n    = state;
    ctrl_n     = ctrl;
    preset_n   = preset;
    count_n    = count;
    irq_flag_n = irq_flag;

    case (state)
      IDLE: begin
        if (en) state_n = LOAD;
      end
      LOAD: begin
        count_n = preset;
        state_n = CNT;
      end
      CNT: begin
        if (!en) begin
          state_n = IDLE;
        end else if (count <= DATA_W'(1)) begin
          // a preset of zero expires on the first counting cycle, like a preset of one
          count_n    = '0;
          irq_flag_n = 1'b1;
          state_n    = INT;
        end else begin
          count_n = count - DATA_W'(1);
        end
      end
      INT: begin
        if (auto_reload) begin
          irq_flag_n = 1'b0;
          state_n    = LOAD;
        end else begin
          ctrl_n[0] = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (wr_ctrl || wr_preset) begin
      state_n    = IDLE;
      irq_flag_n = 1'b0;
      count_n    = count;
      ctrl_n     = wr_ctrl   ? bus.din[CTRL_W-1:0] : ctrl;
      preset_n   = wr_preset ? bus.din : preset;
    end
  end

  // Read mux: purely a function of addr and the registers
  always_comb begin
    case (bus.addr)
      ADDR_CTRL:   bus.dout = {(DATA_W-CTRL_W)'(0), ctrl};
      ADDR_PRESET: bus.dout = preset;
      ADDR_COUNT:  bus.dout = count;
      default:     bus.dout = '0;
    endcase
  end

  assign bus.irq = irq_flag & im;

endmodule

// File: tb/tb_timer_irq.sv
// Directed self-checking bench for timer_irq: reset, one-shot, auto-reload,
// masking, write/expiry collision, preset zero and mid-operation reset.
module tb_timer_irq;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  timer_if bus ();

  timer_irq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "timeout");
  end

  // Advance n rising edges, ending 1 time unit after the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single-cycle register write; the write edge is the edge this task waits on.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.din  = d;
    bus.we   = 1'b1;
    @(posedge clk);
    #1;
    bus.we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.dout;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    bus.we = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    // load non-zero state, then reset while a write is also presented
    wr(2'd1, 32'hDEAD_BEEF);
    wr(2'd0, 32'h0000_000F);
    step(4);
    rst      = 1'b1;
    bus.addr = 2'd1;
    bus.din  = 32'h1234_5678;
    bus.we   = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    bus.we = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      tests++;
      if (v !== 32'h0) begin
        fails++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h", a, v, 32'h0);
      end
    end
    tests++;
    if (bus.irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_irq got=%b exp=0", bus.irq);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    logic [31:0] exp_cnt;
    logic        exp_irq;
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      exp_irq = (k >= 7);
      tests++;
      if (bus.irq !== exp_irq) begin
        fails++;
        $display("FAIL oneshot_irq edge=%0d got=%b exp=%b", k, bus.irq, exp_irq);
      end
      if (k >= 2) begin
        exp_cnt = (k <= 7) ? 32'(7 - k) : 32'd0;
        rd(2'd2, v);
        tests++;
        if (v !== exp_cnt) begin
          fails++;
          $display("FAIL oneshot_count edge=%0d got=%0d exp=%0d", k, v, exp_cnt);
        end
      end
    end
    rd(2'd0, v);
    tests++;
    if (v !== 32'h8) begin
      fails++;
      $display("FAIL oneshot_ctrl got=%h exp=%h", v, 32'h8);
    end
    step(5);
    tests++;
    if (bus.irq !== 1'b1) begin
      fails++;
      $display("FAIL oneshot_hold got=%b exp=1", bus.irq);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    logic        exp_irq;
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 22; k++) begin
      // ignored writes to COUNT and the unmapped address mid-stream
      if (k == 8 || k == 14) begin
        bus.addr = (k == 8) ? 2'd3 : 2'd2;
        bus.din  = 32'hFFFF_FFFF;
        bus.we   = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.we  = 1'b0;
      exp_irq = (k >= 5) && (((k - 5) % 5) == 0);
      tests++;
      if (bus.irq !== exp_irq) begin
        fails++;
        $display("FAIL auto_irq edge=%0d got=%b exp=%b", k, bus.irq, exp_irq);
      end
    end
    rd(2'd0, v);
    tests++;
    if (v !== 32'hB) begin
      fails++;
      $display("FAIL auto_ctrl got=%h exp=%h", v, 32'hB);
    end
  endtask

  task automatic test_masked();
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    step(6);
    tests++;
    if (bus.irq !== 1'b0) begin
      fails++;
      $display("FAIL masked_irq got=%b exp=0", bus.irq);
    end
    rd(2'd0, v);
    tests++;
    if (v !== 32'h0) begin
      fails++;
      $display("FAIL masked_ctrl got=%h exp=%h", v, 32'h0);
    end
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, v);
    tests++;
    if (v !== 32'h0 || bus.irq !== 1'b0) begin
      fails++;
      $display("FAIL masked_cntwrite count=%h irq=%b exp count=0 irq=0", v, bus.irq);
    end
    wr(2'd0, 32'h8);
    for (int k = 0; k < 4; k++) begin
      step(1);
      tests++;
      if (bus.irq !== 1'b0) begin
        fails++;
        $display("FAIL masked_after_unmask cyc=%0d got=%b exp=0", k, bus.irq);
      end
    end
  endtask

  task automatic test_write_at_expiry();
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    step(6);
    wr(2'd0, 32'h8);
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (bus.irq !== 1'b0) begin
        fails++;
        $display("FAIL collide_irq cyc=%0d got=%b exp=0", k, bus.irq);
      end
      step(1);
    end
    rd(2'd2, v);
    tests++;
    if (v !== 32'd1) begin
      fails++;
      $display("FAIL collide_count got=%0d exp=1", v);
    end
    rd(2'd0, v);
    tests++;
    if (v !== 32'h8) begin
      fails++;
      $display("FAIL collide_ctrl got=%h exp=%h", v, 32'h8);
    end
  endtask

  task automatic test_preset_zero();
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    step(2);
    tests++;
    if (bus.irq !== 1'b0) begin
      fails++;
      $display("FAIL preset0_early got=%b exp=0", bus.irq);
    end
    step(1);
    tests++;
    if (bus.irq !== 1'b1) begin
      fails++;
      $display("FAIL preset0_fire got=%b exp=1", bus.irq);
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] v;
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), v);
      tests++;
      if (v !== 32'h0) begin
        fails++;
        $display("FAIL %s_read addr=%0d got=%h exp=0", tag, a, v);
      end
    end
    tests++;
    if (bus.irq !== 1'b0) begin
      fails++;
      $display("FAIL %s_irq got=%b exp=0", tag, bus.irq);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    step(5);
    rd(2'd2, v);
    tests++;
    if (v !== 32'd2) begin
      fails++;
      $display("FAIL midreset_pre count=%0d exp=2", v);
    end
    do_reset();
    check_all_zero("midreset_cnt");
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    step(5);
    tests++;
    if (bus.irq !== 1'b1) begin
      fails++;
      $display("FAIL midreset_int_pre got=%b exp=1", bus.irq);
    end
    do_reset();
    check_all_zero("midreset_int");
    for (int k = 0; k < 12; k++) begin
      step(1);
      tests++;
      if (bus.irq !== 1'b0) begin
        fails++;
        $display("FAIL midreset_quiet cyc=%0d got=%b exp=0", k, bus.irq);
      end
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    bus.addr = 2'd0;
    bus.we   = 1'b0;
    bus.din  = 32'h0;
    step(2);
    rst = 1'b0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_masked();
    test_write_at_expiry();
    test_preset_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
